mux_16_1: RTL and testbench

MUX_16_1 -- requirements
Module: mux_16_1

---
 rtl/mux_16_1_pkg.sv | 15 +
 rtl/mux_16_1.sv | 77 +++++++
 tb/tb_mux_16_1.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/mux_16_1_pkg.sv
// Shared constants for the 16:1 registered multiplexer.
// Select range helper is used when MUX_16_1_SEL_ERR_EN is defined.
package mux_16_1_pkg;

   localparam int NUM_INPUTS    = 16;
   localparam int SEL_WIDTH     = 8;
   localparam int DEFAULT_WIDTH = 32;

   function automatic logic sel_in_range(
      input logic [SEL_WIDTH-1:0] sel
   );
      return sel < SEL_WIDTH'(NUM_INPUTS);
   endfunction

endpackage

// File: rtl/mux_16_1.sv
// Registered 16:1 mux, one-cycle latency, zero for select > 15.
// Optional sel_err flag enabled by MUX_16_1_SEL_ERR_EN.
module mux_16_1
   import mux_16_1_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [SEL_WIDTH-1:0] select,
   input  logic [WIDTH-1:0]     in_00,
   input  logic [WIDTH-1:0]     in_01,
   input  logic [WIDTH-1:0]     in_02,
   input  logic [WIDTH-1:0]     in_03,
   input  logic [WIDTH-1:0]     in_04,
   input  logic [WIDTH-1:0]     in_05,
   input  logic [WIDTH-1:0]     in_06,
   input  logic [WIDTH-1:0]     in_07,
   input  logic [WIDTH-1:0]     in_08,
   input  logic [WIDTH-1:0]     in_09,
   input  logic [WIDTH-1:0]     in_10,
   input  logic [WIDTH-1:0]     in_11,
   input  logic [WIDTH-1:0]     in_12,
   input  logic [WIDTH-1:0]     in_13,
   input  logic [WIDTH-1:0]     in_14,
   input  logic [WIDTH-1:0]     in_15,
`ifdef MUX_16_1_SEL_ERR_EN
   output logic                 sel_err,
`endif
   output logic [WIDTH-1:0]     output_data
);

   logic [WIDTH-1:0] next_data;

   // Full 8-bit compare: 16..255 fall to default, never wrap.
   always_comb begin
      next_data = '0;
      unique case (select)
         8'd0:    next_data = in_00;
         8'd1:    next_data = in_01;
         8'd2:    next_data = in_02;
         8'd3:    next_data = in_03;
         8'd4:    next_data = in_04;
         8'd5:    next_data = in_05;
         8'd6:    next_data = in_06;
         8'd7:    next_data = in_07;
         8'd8:    next_data = in_08;
         8'd9:    next_data = in_09;
         8'd10:   next_data = in_10;
         8'd11:   next_data = in_11;
         8'd12:   next_data = in_12;
         8'd13:   next_data = in_13;
         8'd14:   next_data = in_14;
         8'd15:   next_data = in_15;
         default: next_data = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         output_data <= '0;
      end else begin
         output_data <= next_data;
      end
   end

`ifdef MUX_16_1_SEL_ERR_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sel_err <= 1'b0;
      end else begin
         sel_err <= !sel_in_range(select);
      end
   end
`endif

endmodule

// File: tb/tb_mux_16_1.sv
// Bench for mux_16_1: directed steps plus random traffic vs array model.
// Checks sel_err as well when MUX_16_1_SEL_ERR_EN is defined.
module tb_mux_16_1;

   logic        clk;
   logic        rst_n;
   logic [7:0]  sel;
   logic [31:0] din  [16];
   logic [7:0]  din8 [16];
   logic [31:0] dout;
   logic [7:0]  dout8;
`ifdef MUX_16_1_SEL_ERR_EN
   logic        err;
   logic        err8;
`endif

   int checks   = 0;
   int failures = 0;

   mux_16_1 #(.WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n), .select(sel),
      .in_00(din[0]),  .in_01(din[1]),  .in_02(din[2]),
      .in_03(din[3]),  .in_04(din[4]),  .in_05(din[5]),
      .in_06(din[6]),  .in_07(din[7]),  .in_08(din[8]),
      .in_09(din[9]),  .in_10(din[10]), .in_11(din[11]),
      .in_12(din[12]), .in_13(din[13]), .in_14(din[14]),
      .in_15(din[15]),
`ifdef MUX_16_1_SEL_ERR_EN
      .sel_err(err),
`endif
      .output_data(dout)
   );

   mux_16_1 #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .select(sel),
      .in_00(din8[0]),  .in_01(din8[1]),  .in_02(din8[2]),
      .in_03(din8[3]),  .in_04(din8[4]),  .in_05(din8[5]),
      .in_06(din8[6]),  .in_07(din8[7]),  .in_08(din8[8]),
      .in_09(din8[9]),  .in_10(din8[10]), .in_11(din8[11]),
      .in_12(din8[12]), .in_13(din8[13]), .in_14(din8[14]),
      .in_15(din8[15]),
`ifdef MUX_16_1_SEL_ERR_EN
      .sel_err(err8),
`endif
      .output_data(dout8)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference: pick the addressed word, zero when out of range.
   function automatic logic [31:0] ref32(input int s);
      return (s < 16) ? din[s] : 32'h0;
   endfunction

   function automatic logic [7:0] ref8(input int s);
      return (s < 16) ? din8[s] : 8'h0;
   endfunction

   task automatic check(input string tag,
                        input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   logic [31:0] exp32;
   logic [7:0]  exp8;
   logic        exp_err;

   // Capture model values now, clock once, then compare.
   task automatic step(input string tag);
      exp32   = ref32(int'(sel));
      exp8    = ref8(int'(sel));
      exp_err = (int'(sel) > 15);
      @(posedge clk);
      #1;
      check(tag, dout, exp32);
      check({tag, "_w8"}, {24'h0, dout8}, {24'h0, exp8});
`ifdef MUX_16_1_SEL_ERR_EN
      check({tag, "_err"}, {31'h0, err}, {31'h0, exp_err});
      check({tag, "_err8"}, {31'h0, err8}, {31'h0, exp_err});
`endif
   endtask

   initial begin
      rst_n = 1'b0;
      sel   = 8'd0;
      for (int i = 0; i < 16; i++) begin
         din[i]  = 32'h7000_0000 + 32'(i);
         din8[i] = 8'(i);
      end

      repeat (2) @(posedge clk);
      #1;
      check("reset_data", dout, 32'h0);
      check("reset_data_w8", {24'h0, dout8}, 32'h0);
`ifdef MUX_16_1_SEL_ERR_EN
      check("reset_err", {31'h0, err}, 32'h0);
`endif
      rst_n = 1'b1;

      for (int s = 0; s < 16; s++) begin
         sel = 8'(s);
         step($sformatf("sweep_%0d", s));
      end

      sel = 8'd16;
      step("sel_16");
      sel = 8'd255;
      step("sel_255");
      sel = 8'd3;
      step("sel_3_after_oor");
      sel = 8'd19;
      step("sel_19_no_wrap");

      sel = 8'd5;
      step("hold5_base");
      din[5] = 32'hDEAD_BEEF;
      step("hold5_new");
      for (int k = 0; k < 4; k++) begin
         for (int i = 0; i < 16; i++)
            if (i != 5) din[i] = ~din[i];
         step($sformatf("hold5_toggle_%0d", k));
      end
      din[5] = 32'h7000_0005;
      step("hold5_restore");

      sel = 8'd10;
      step("pre_reset");
      #2;
      rst_n = 1'b0;
      #1;
      check("async_reset", dout, 32'h0);
      check("async_reset_w8", {24'h0, dout8}, 32'h0);
      #1;
      rst_n = 1'b1;
      #1;
      check("post_release_hold", dout, 32'h0);
      for (int i = 0; i < 16; i++)
         din[i] = 32'h7000_0000 + 32'(i);
      step("first_after_reset");

      sel = 8'd15;
      step("w8_sel15");

      for (int n = 0; n < 60; n++) begin
         for (int i = 0; i < 16; i++) begin
            din[i]  = $urandom;
            din8[i] = 8'($urandom);
         end
         if ($urandom_range(0, 3) == 0)
            sel = 8'($urandom_range(0, 255));
         else
            sel = 8'($urandom_range(0, 20));
         step($sformatf("rand_%0d_sel%0d", n, sel));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
